// File: rtl/phase_timer_pkg.sv
// Shared types and constants for the phase timer and the traffic-light FSM it feeds.
package phase_timer_pkg;

    localparam int unsigned PHASE_LEN_DEFAULT = 10;
    localparam int unsigned T_W               = 4;
    localparam int unsigned QUAL_W            = 8;

    // One-hot light codes used by the light FSM
    localparam logic [2:0] RED    = 3'b100;
    localparam logic [2:0] YELLOW = 3'b010;
    localparam logic [2:0] GREEN  = 3'b001;

    typedef enum logic [1:0] {
        V_IDLE = 2'd0,
        V_QUAL = 2'd1,
        V_REQ  = 2'd2
    } veh_state_e;

endpackage

// File: rtl/vehicle_debounce.sv
// Synchronizes the raw road sensor and qualifies it into a latched vehicle request.
module vehicle_debounce
    import phase_timer_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic vehicle_raw,
    input  logic veh_ack,
    output logic vehicle
);

    localparam logic [QUAL_W-1:0] QUAL_TARGET = QUAL_W'(DEBOUNCE_CYC);

    logic              sync1_q, sync1_d;
    logic              sync2_q, sync2_d;
    logic              vehicle_q, vehicle_d;
    logic              vehicle_s;
    veh_state_e        state_q, state_d;
    logic [QUAL_W-1:0] qual_cnt_q, qual_cnt_d;

    assign vehicle_s = sync2_q;
    assign vehicle   = vehicle_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            state_q    <= V_IDLE;
            qual_cnt_q <= '0;
            vehicle_q  <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            state_q    <= state_d;
            qual_cnt_q <= qual_cnt_d;
            vehicle_q  <= vehicle_d;
        end
    end

    // Once latched, the request survives a dropped sensor until the light FSM acks it
    always_comb begin
        sync1_d    = vehicle_raw;
        sync2_d    = sync1_q;
        state_d    = state_q;
        qual_cnt_d = qual_cnt_q;
        case (state_q)
            V_IDLE: begin
                if (vehicle_s) begin
                    state_d    = V_QUAL;
                    qual_cnt_d = QUAL_W'(1);
                end
            end
            V_QUAL: begin
                if (!vehicle_s) begin
                    state_d    = V_IDLE;
                    qual_cnt_d = '0;
                end else if (qual_cnt_q == QUAL_TARGET) begin
                    state_d = V_REQ;
                end else begin
                    qual_cnt_d = qual_cnt_q + QUAL_W'(1);
                end
            end
            V_REQ: begin
                if (veh_ack) begin
                    state_d    = V_IDLE;
                    qual_cnt_d = '0;
                end
            end
            default: begin
                state_d    = V_IDLE;
                qual_cnt_d = '0;
            end
        endcase
        vehicle_d = (state_d == V_REQ);
    end

endmodule

// File: rtl/phase_timer.sv
// Phase timer: prescaled tick, phase counter with one-cycle expire, debounced vehicle request.
// Optional macro PHASE_TIMER_PAUSE_EN adds a pause input that freezes the timer path.
module phase_timer
    import phase_timer_pkg::*;
#(
    parameter int unsigned CLK_DIV      = 4,
    parameter int unsigned PHASE_LEN    = PHASE_LEN_DEFAULT,
    parameter int unsigned DEBOUNCE_CYC = 3
) (
    input  logic           clk,
    input  logic           rst,
`ifdef PHASE_TIMER_PAUSE_EN
    input  logic           pause,
`endif
    input  logic           phase_restart,
    input  logic           vehicle_raw,
    input  logic           veh_ack,
    output logic [T_W-1:0] t,
    output logic           tick,
    output logic           expire,
    output logic           vehicle
);

    localparam int unsigned        DIV_W    = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [T_W-1:0]     T_END    = T_W'(PHASE_LEN);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [T_W-1:0]   t_q, t_d;
    logic             run_c;

`ifdef PHASE_TIMER_PAUSE_EN
    assign run_c = !pause;
`else
    assign run_c = 1'b1;
`endif

    assign t      = t_q;
    assign tick   = run_c && (div_cnt_q == DIV_LAST);
    assign expire = (t_q == T_END);

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q <= '0;
            t_q       <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
            t_q       <= t_d;
        end
    end

    // Phase wrap restarts the prescaler too, so every phase is PHASE_LEN*CLK_DIV+1 clocks
    always_comb begin
        div_cnt_d = div_cnt_q;
        t_d       = t_q;
        if (phase_restart) begin
            div_cnt_d = '0;
            t_d       = '0;
        end else if (run_c) begin
            if (expire) begin
                div_cnt_d = '0;
                t_d       = '0;
            end else if (tick) begin
                div_cnt_d = '0;
                t_d       = t_q + T_W'(1);
            end else begin
                div_cnt_d = div_cnt_q + DIV_W'(1);
            end
        end
    end

    vehicle_debounce #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_debounce (
        .clk         (clk),
        .rst         (rst),
        .vehicle_raw (vehicle_raw),
        .veh_ack     (veh_ack),
        .vehicle     (vehicle)
    );

endmodule

// File: tb/tb_phase_timer.sv
// Scoreboard bench for phase_timer (CLK_DIV=4, PHASE_LEN=10, DEBOUNCE_CYC=3).
module tb_phase_timer;

    localparam int SEL_T   = 0;
    localparam int SEL_TCK = 1;
    localparam int SEL_EXP = 2;
    localparam int SEL_VEH = 3;

    typedef struct {
        int         cyc;
        int         sel;
        logic [3:0] val;
        string      name;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       phase_restart;
    logic       vehicle_raw;
    logic       veh_ack;
`ifdef PHASE_TIMER_PAUSE_EN
    logic       pause;
`endif
    logic [3:0] t;
    logic       tick;
    logic       expire;
    logic       vehicle;

    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    exp_t sb[$];
    exp_t e;
    logic [3:0] act;

    phase_timer #(
        .CLK_DIV      (4),
        .PHASE_LEN    (10),
        .DEBOUNCE_CYC (3)
    ) dut (
        .clk           (clk),
        .rst           (rst),
`ifdef PHASE_TIMER_PAUSE_EN
        .pause         (pause),
`endif
        .phase_restart (phase_restart),
        .vehicle_raw   (vehicle_raw),
        .veh_ack       (veh_ack),
        .t             (t),
        .tick          (tick),
        .expire        (expire),
        .vehicle       (vehicle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare queued expectations against the DUT once per cycle
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            case (e.sel)
                SEL_T:   act = t;
                SEL_TCK: act = {3'b000, tick};
                SEL_EXP: act = {3'b000, expire};
                default: act = {3'b000, vehicle};
            endcase
            n_vec = n_vec + 1;
            if (e.cyc != cyc || act !== e.val) begin
                n_err = n_err + 1;
                $display("FAIL %s: cycle %0d got %0d expected %0d", e.name, cyc, act, e.val);
            end
        end
    end

    task automatic at(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic chk(input int sel, input int val, input string nm);
        exp_t x;
        x.cyc  = cyc;
        x.sel  = sel;
        x.val  = 4'(val);
        x.name = nm;
        sb.push_back(x);
    endtask

    initial begin
        int b;
        int b2;
        int b3;
        int v;
        int g;
        int q;
        int x;
        int y;
        rst           = 1'b1;
        phase_restart = 1'b0;
        vehicle_raw   = 1'b0;
        veh_ack       = 1'b0;
`ifdef PHASE_TIMER_PAUSE_EN
        pause         = 1'b0;
`endif
        at(1);
        chk(SEL_T, 0, "rst_t");
        chk(SEL_TCK, 0, "rst_tick");
        chk(SEL_EXP, 0, "rst_expire");
        chk(SEL_VEH, 0, "rst_vehicle");
        at(2);
        rst = 1'b0;

        // Free run: tick every 4th cycle, t=10 for one cycle, period 41
        b = cyc;
        at(b + 3);  chk(SEL_TCK, 1, "run_first_tick"); chk(SEL_T, 0, "run_t0");
        at(b + 4);  chk(SEL_T, 1, "run_t1");           chk(SEL_TCK, 0, "run_notick");
        at(b + 39); chk(SEL_T, 9, "run_t9");           chk(SEL_TCK, 1, "run_tick9");
        at(b + 40); chk(SEL_T, 10, "run_t10");         chk(SEL_EXP, 1, "run_expire");
        at(b + 41); chk(SEL_T, 0, "run_wrap");         chk(SEL_EXP, 0, "run_expire_off");
        at(b + 43); chk(SEL_TCK, 0, "run_no_early_tick");
        at(b + 44); chk(SEL_TCK, 1, "run_tick_after_wrap");
        at(b + 45); chk(SEL_T, 1, "run2_t1");
        at(b + 81); chk(SEL_T, 10, "run2_t10");        chk(SEL_EXP, 1, "run2_expire");
        at(b + 82); chk(SEL_T, 0, "run2_wrap");

        // Restart at t=6, then restart on the t=9 tick cycle
        b2 = b + 82;
        at(b2 + 25); chk(SEL_T, 6, "rs_t6"); phase_restart = 1'b1;
        at(b2 + 26); phase_restart = 1'b0; chk(SEL_T, 0, "rs_t_clear"); chk(SEL_TCK, 0, "rs_notick");
        at(b2 + 28); chk(SEL_TCK, 0, "rs_div_cleared");
        at(b2 + 29); chk(SEL_TCK, 1, "rs_tick_4_later");
        at(b2 + 30); chk(SEL_T, 1, "rs_t1");
        b3 = b2 + 26;
        at(b3 + 39); chk(SEL_T, 9, "rs9_t9"); chk(SEL_TCK, 1, "rs9_tick"); phase_restart = 1'b1;
        at(b3 + 40); phase_restart = 1'b0; chk(SEL_T, 0, "rs9_t_not10"); chk(SEL_EXP, 0, "rs9_noexpire");
        at(b3 + 43); chk(SEL_TCK, 1, "rs9_tick_again");

        // Vehicle qualification latency, latch hold, ack and requalify
        v = b3 + 50;
        at(v);      vehicle_raw = 1'b1;
        at(v + 5);  chk(SEL_VEH, 0, "veh_before_qual");
        at(v + 6);  chk(SEL_VEH, 1, "veh_latency"); vehicle_raw = 1'b0;
        at(v + 30); chk(SEL_VEH, 1, "veh_hold_30");
        at(v + 56); chk(SEL_VEH, 1, "veh_hold_50"); vehicle_raw = 1'b1;
        at(v + 60); veh_ack = 1'b1;
        at(v + 61); veh_ack = 1'b0; chk(SEL_VEH, 0, "veh_acked");
        at(v + 64); chk(SEL_VEH, 0, "veh_requal_pending");
        at(v + 65); chk(SEL_VEH, 1, "veh_requal"); vehicle_raw = 1'b0;
        at(v + 70); veh_ack = 1'b1;
        at(v + 71); veh_ack = 1'b0; chk(SEL_VEH, 0, "veh_ack2");
        at(v + 75); chk(SEL_VEH, 0, "veh_idle_stays");

        // Two-cycle glitch never qualifies
        g = v + 80;
        at(g);     vehicle_raw = 1'b1;
        at(g + 2); vehicle_raw = 1'b0;
        for (int i = 3; i <= 9; i++) begin
            at(g + i); chk(SEL_VEH, 0, "glitch");
        end

        // Ack during qualification is ignored
        q = g + 20;
        at(q);     vehicle_raw = 1'b1;
        at(q + 4); veh_ack = 1'b1;
        at(q + 5); veh_ack = 1'b0; chk(SEL_VEH, 0, "qack_pending");
        at(q + 6); chk(SEL_VEH, 1, "qack_ignored"); vehicle_raw = 1'b0;
        at(q + 8); veh_ack = 1'b1;
        at(q + 9); veh_ack = 1'b0; chk(SEL_VEH, 0, "qack_clear");

        // Reset mid-phase (t=7) and mid-qualification
        x = q + 20;
        at(x);     phase_restart = 1'b1;
        at(x + 1); phase_restart = 1'b0;
        y = x + 29;
        at(y - 3); vehicle_raw = 1'b1;
        at(y);     chk(SEL_T, 7, "mid_t7"); chk(SEL_VEH, 0, "mid_qual"); rst = 1'b1;
        at(y + 1); rst = 1'b0;
        chk(SEL_T, 0, "mrst_t"); chk(SEL_TCK, 0, "mrst_tick");
        chk(SEL_EXP, 0, "mrst_expire"); chk(SEL_VEH, 0, "mrst_vehicle");
        at(y + 4); chk(SEL_TCK, 1, "mrst_tick_grid");
        at(y + 5); chk(SEL_T, 1, "mrst_t1");
        at(y + 6); chk(SEL_VEH, 0, "mrst_requal_pending");
        at(y + 7); chk(SEL_VEH, 1, "mrst_requal");

        // Simultaneous restart and ack
        at(y + 10); phase_restart = 1'b1; veh_ack = 1'b1;
        at(y + 11); phase_restart = 1'b0; veh_ack = 1'b0;
        chk(SEL_T, 0, "both_t"); chk(SEL_VEH, 0, "both_vehicle");
        at(y + 12); chk(SEL_TCK, 0, "both_div_cleared");
        at(y + 14); chk(SEL_TCK, 1, "both_tick"); chk(SEL_VEH, 0, "both_requal_pending");
        at(y + 15); chk(SEL_VEH, 1, "both_requal"); vehicle_raw = 1'b0;

`ifdef PHASE_TIMER_PAUSE_EN
        // Pause at t=3 freezes t and suppresses tick
        begin
            int p;
            p = y + 20;
            at(p);      phase_restart = 1'b1;
            at(p + 1);  phase_restart = 1'b0;
            at(p + 13); pause = 1'b1;
            for (int i = 13; i <= 20; i++) begin
                at(p + i); chk(SEL_T, 3, "pause_t"); chk(SEL_TCK, 0, "pause_tick");
            end
            at(p + 21); pause = 1'b0; chk(SEL_T, 3, "pause_release");
            at(p + 24); chk(SEL_TCK, 1, "pause_resume_tick");
            at(p + 25); chk(SEL_T, 4, "pause_resume_t");
        end
`endif

        at(cyc + 3);
        if (sb.size() != 0) begin
            n_err = n_err + 1;
            $display("FAIL scoreboard_drain: %0d expectations left, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/phase_timer.md
PHASE_TIMER -- requirements
Module: phase_timer

Interface
REQ-001 Parameter CLK_DIV, default 4, clocks per timer tick; legal range 2..2^24.
REQ-002 Parameter PHASE_LEN, default 10, tick count that ends a phase; legal range 1..15.
REQ-003 Parameter DEBOUNCE_CYC, default 3, consecutive synchronized-high cycles that qualify a vehicle; legal range 1..255.
REQ-004 clk  input  1  sole clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 phase_restart  input  1  one-cycle pulse from the light FSM on any state change; clears the phase count.
REQ-007 vehicle_raw  input  1  asynchronous, bouncy road-sensor level.
REQ-008 veh_ack  input  1  one-cycle pulse from the light FSM; consumes the pending vehicle request.
REQ-009 t  output  4  phase time in ticks, drives the light FSM time input.
REQ-010 tick  output  1  one-cycle pulse per CLK_DIV clocks.
REQ-011 expire  output  1  high exactly in the cycle t == PHASE_LEN.
REQ-012 vehicle  output  1  debounced, latched vehicle request.

Function
REQ-013 Prescaler div_cnt, width $clog2(CLK_DIV), SHALL count 0..CLK_DIV-1 and wrap to 0; tick SHALL be 1 in the cycle div_cnt == CLK_DIV-1.
REQ-014 On tick with t < PHASE_LEN, t SHALL increment by 1 in the next cycle.
REQ-015 When t == PHASE_LEN, t SHALL return to 0 in the next cycle regardless of tick, so t == PHASE_LEN lasts exactly one clock.
REQ-016 expire SHALL be combinational (t == PHASE_LEN) with zero latency.
REQ-017 phase_restart SHALL clear t and div_cnt to 0 in the next cycle and has priority over tick and the wrap in REQ-015.
REQ-018 vehicle_raw SHALL pass a 2-flop synchronizer before any use; output vehicle_s.
REQ-019 Debounce FSM states: V_IDLE, V_QUAL, V_REQ; encoding is 2 bits.
REQ-020 V_IDLE: vehicle_s=1 -> V_QUAL, qual_cnt=1; otherwise stay.
REQ-021 V_QUAL: vehicle_s=0 -> V_IDLE, qual_cnt=0; qual_cnt == DEBOUNCE_CYC -> V_REQ; else increment qual_cnt.
REQ-022 V_REQ: vehicle=1; stays until veh_ack, then -> V_IDLE, qual_cnt=0; a low vehicle_s does not clear V_REQ.
REQ-023 Latency: vehicle_raw held high from edge k SHALL give vehicle=1 at edge k+2+DEBOUNCE_CYC.
REQ-024 veh_ack in any state other than V_REQ SHALL be ignored; if vehicle_raw is still high after ack, requalification takes a full DEBOUNCE_CYC again.
REQ-025 The timer path and the debounce path SHALL be independent; simultaneous phase_restart and veh_ack both take effect.

Reset
REQ-026 rst SHALL, on the next edge, set t=0, div_cnt=0, tick=0, expire=0, vehicle=0, synchronizer flops=0, debounce state V_IDLE, qual_cnt=0.
REQ-027 rst mid-phase or mid-qualification SHALL discard all progress; rst has priority over every other input.

Configuration
REQ-028 Macro PHASE_TIMER_PAUSE_EN, when defined, SHALL add input port pause (1 bit); while pause=1, div_cnt and t hold, tick=0, and phase_restart and rst still take effect.
REQ-029 Without PHASE_TIMER_PAUSE_EN there SHALL be no pause port and the timer free-runs; the debounce path is unaffected in both builds.

Structure
REQ-030 Package phase_timer_pkg SHALL hold the debounce state enum (V_IDLE, V_QUAL, V_REQ), the default PHASE_LEN (10), and the RED/YELLOW/GREEN 3-bit one-hot codes shared with the light FSM.
REQ-031 The synchronizer and debounce FSM SHALL be a sub-module vehicle_debounce; the prescaler and phase counter stay in phase_timer.

Verification (CLK_DIV=4, PHASE_LEN=10, DEBOUNCE_CYC=3)
REQ-032 Free run after rst: tick every 4th cycle; t steps 0..10, t=10 and expire=1 for 1 cycle, then t=0; period 41 cycles.
REQ-033 phase_restart asserted at t=6: t=0 and div_cnt=0 next cycle; the next tick comes 4 cycles later; phase_restart on a tick cycle with t=9 gives t=0, not 10.
REQ-034 vehicle_raw high from edge 20: vehicle=1 at edge 25; a 2-cycle glitch gives vehicle=0 throughout.
REQ-035 vehicle latched, vehicle_raw dropped, no ack for 50 cycles: vehicle stays 1; veh_ack gives vehicle=0 next cycle; raw still high -> vehicle=1 again 4 cycles after ack.
REQ-036 rst asserted with t=7 and debounce in V_QUAL: all outputs 0 next cycle; PHASE_TIMER_PAUSE_EN build: pause=1 at t=3 holds t=3 and tick=0 for the pause duration.
